// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : logic_unit_pipe                                              |
// | Description : Two-stage valid/ready W-bit bitwise logic unit (8 functions).|
// |               Define LOGIC_UNIT_SELFTEST_EN to add a NAND-only shadow path,|
// |               mismatch counter and truth-table self-test sequencer.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module logic_unit_pipe #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    input  logic         selftest_start,
    output logic         selftest_busy,
    output logic         selftest_done,
    output logic         selftest_pass,
    output logic [7:0]   err_count
);

    localparam logic [2:0] c_op_nor  = 3'd0;
    localparam logic [2:0] c_op_nand = 3'd1;
    localparam logic [2:0] c_op_and  = 3'd2;
    localparam logic [2:0] c_op_or   = 3'd3;
    localparam logic [2:0] c_op_xor  = 3'd4;
    localparam logic [2:0] c_op_xnor = 3'd5;
    localparam logic [2:0] c_op_not  = 3'd6;

    logic         r_s1_valid;
    logic         r_s1_tag;
    logic [2:0]   r_s1_op;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;
    logic         r_s2_valid;
    logic         r_s2_tag;
    logic [W-1:0] r_s2_res;

    logic         w_idle;
    logic         w_run;
    logic         w_advance;
    logic         w_take;
    logic [2:0]   w_vec_op;
    logic [W-1:0] w_vec_a;
    logic [W-1:0] w_vec_b;
    logic         w_inj_valid;
    logic         w_inj_tag;
    logic [2:0]   w_inj_op;
    logic [W-1:0] w_inj_a;
    logic [W-1:0] w_inj_b;
    logic [W-1:0] w_expr;

    function automatic logic [W-1:0] f_expr(input logic [2:0] f_op,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (f_op)
            c_op_nor:  f_expr = ~(x | y);
            c_op_nand: f_expr = ~(x & y);
            c_op_and:  f_expr = x & y;
            c_op_or:   f_expr = x | y;
            c_op_xor:  f_expr = x ^ y;
            c_op_xnor: f_expr = ~(x ^ y);
            c_op_not:  f_expr = ~x;
            default:   f_expr = x;
        endcase
    endfunction

    assign out_valid = r_s2_valid && r_s2_tag;
    assign s         = out_valid ? r_s2_res : '0;
    // The self-test only runs on a pipe free of external items, so forcing
    // advance in RUN never overrides a pending consumer stall.
    assign w_advance = !out_valid || out_ready || w_run;
    assign in_ready  = !rst && w_advance && w_idle;
    assign w_take    = in_valid && in_ready;
    assign w_expr    = f_expr(r_s1_op, r_s1_a, r_s1_b);

    always_comb begin
        w_inj_valid = w_take;
        w_inj_tag   = 1'b1;
        w_inj_op    = op;
        w_inj_a     = a;
        w_inj_b     = b;
        if (w_run) begin
            w_inj_valid = 1'b1;
            w_inj_tag   = 1'b0;
            w_inj_op    = w_vec_op;
            w_inj_a     = w_vec_a;
            w_inj_b     = w_vec_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= 1'b0;
            r_s1_op    <= 3'd0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_tag   <= 1'b0;
            r_s2_res   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_inj_valid;
            r_s1_tag   <= w_inj_tag;
            r_s1_op    <= w_inj_op;
            r_s1_a     <= w_inj_a;
            r_s1_b     <= w_inj_b;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            r_s2_res   <= w_expr;
        end
    end

`ifdef LOGIC_UNIT_SELFTEST_EN
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wait  = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]   r_state;
    logic [2:0]   w_state_nxt;
    logic [4:0]   r_idx;
    logic         r_drain;
    logic         r_seen;
    logic         r_pass;
    logic [7:0]   r_err;
    logic [W-1:0] w_shadow;
    logic [W-1:0] r_s2_shadow;
    logic         w_mismatch;
    logic         w_ext_inflight;

    function automatic logic f_nand(input logic x, input logic y);
        f_nand = ~(x & y);
    endfunction

    // Every function is rebuilt from 2-input NANDs so a fault in either
    // datapath shows up as a disagreement at stage 2.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_shadow_bit
            logic       w_x, w_y, w_nxy, w_nx, w_ny;
            logic       w_and, w_or, w_nor, w_xor, w_xnor, w_pass;
            logic [7:0] w_fn;
            assign w_x    = r_s1_a[gi];
            assign w_y    = r_s1_b[gi];
            assign w_nxy  = f_nand(w_x, w_y);
            assign w_nx   = f_nand(w_x, w_x);
            assign w_ny   = f_nand(w_y, w_y);
            assign w_and  = f_nand(w_nxy, w_nxy);
            assign w_or   = f_nand(w_nx, w_ny);
            assign w_nor  = f_nand(w_or, w_or);
            assign w_xor  = f_nand(f_nand(w_x, w_nxy), f_nand(w_y, w_nxy));
            assign w_xnor = f_nand(w_xor, w_xor);
            assign w_pass = f_nand(w_nx, w_nx);
            assign w_fn   = {w_pass, w_nx, w_xnor, w_xor, w_or, w_and, w_nxy, w_nor};
            assign w_shadow[gi] = w_fn[r_s1_op];
        end
    endgenerate

    assign w_idle         = (r_state == c_st_idle);
    assign w_run          = (r_state == c_st_run);
    assign w_vec_op       = r_idx[4:2];
    assign w_vec_a        = {W{r_idx[1]}};
    assign w_vec_b        = {W{r_idx[0]}};
    assign w_ext_inflight = (r_s1_valid && r_s1_tag) || (r_s2_valid && r_s2_tag);
    // Counted only when the item leaves stage 2, so a stall counts it once.
    assign w_mismatch     = r_s2_valid && (r_s2_res != r_s2_shadow) && w_advance;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (selftest_start) w_state_nxt = c_st_wait;
            c_st_wait:  if (!w_ext_inflight) w_state_nxt = c_st_run;
            c_st_run:   if (r_idx == 5'd31) w_state_nxt = c_st_drain;
            c_st_drain: if (r_drain) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= 5'd0;
            r_drain     <= 1'b0;
            r_seen      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 8'd0;
            r_s2_shadow <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_run ? r_idx + 5'd1 : 5'd0;
            r_drain <= (r_state == c_st_drain);
            if (w_advance) r_s2_shadow <= w_shadow;
            if (w_mismatch && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
            if (w_idle && (w_state_nxt == c_st_wait)) begin
                r_seen <= 1'b0;
            end else if (w_mismatch) begin
                r_seen <= 1'b1;
            end
            if ((r_state == c_st_drain) && (w_state_nxt == c_st_done)) begin
                r_pass <= !(r_seen || w_mismatch);
            end
        end
    end

    assign selftest_busy = !w_idle;
    assign selftest_done = (r_state == c_st_done);
    assign selftest_pass = r_pass;
    assign err_count     = r_err;
`else
    logic w_unused;

    assign w_idle        = 1'b1;
    assign w_run         = 1'b0;
    assign w_vec_op      = 3'd0;
    assign w_vec_a       = '0;
    assign w_vec_b       = '0;
    assign w_unused      = selftest_start;
    assign selftest_busy = 1'b0;
    assign selftest_done = 1'b0;
    assign selftest_pass = 1'b0;
    assign err_count     = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_logic_unit_pipe                                           |
// | Description : Directed self-checking bench for logic_unit_pipe (W = 4).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_logic_unit_pipe;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         selftest_start;
    logic         selftest_busy;
    logic         selftest_done;
    logic         selftest_pass;
    logic [7:0]   err_count;

    int total = 0;
    int bad   = 0;

    // a = 0011, b = 0101 through ops 0..7
    logic [3:0] tt_exp [8] = '{4'b1000, 4'b1110, 4'b0001, 4'b0111,
                               4'b0110, 4'b1001, 4'b1100, 4'b0011};
    logic [2:0] bp_op  [6] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd7};
    logic [3:0] bp_a   [6] = '{4'b1100, 4'b1100, 4'b1100, 4'b1111, 4'b0001, 4'b1011};
    logic [3:0] bp_b   [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0010, 4'b0000};
    logic [3:0] bp_exp [6] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b1100, 4'b1011};

    always #5 clk = ~clk;

    logic_unit_pipe #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .s              (s),
        .selftest_start (selftest_start),
        .selftest_busy  (selftest_busy),
        .selftest_done  (selftest_done),
        .selftest_pass  (selftest_pass),
        .err_count      (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back issues; item c-1 is at the output after edge c.
    task automatic run_truth_table();
        a = 4'b0011;
        b = 4'b0101;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            op = 3'(c);
            #1;
            if (c < 8) check($sformatf("tt_in_ready%0d", c), 32'(in_ready), 32'd1);
            step();
            if (c == 0) begin
                check("tt_latency_empty", 32'(out_valid), 32'd0);
            end else if (c <= 8) begin
                check($sformatf("tt_valid_op%0d", c - 1), 32'(out_valid), 32'd1);
                check($sformatf("tt_s_op%0d", c - 1), 32'(s), 32'(tt_exp[c - 1]));
            end else begin
                check("tt_drained", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int rcv;
        int hold;
        int done_at;
        logic fire;
        logic ov_seen;

        rst = 1'b1;
        in_valid = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        selftest_start = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_busy", 32'(selftest_busy), 32'd0);
        check("rst_pass", 32'(selftest_pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        repeat (2) step();
        check("rst_in_ready_held", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        run_truth_table();

        // Back-pressure: hold the consumer for 3 cycles while item 2 is presented
        sent = 0;
        rcv = 0;
        hold = 0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            out_ready = !(out_valid && rcv == 2 && hold < 3);
            in_valid = (sent < 6);
            if (sent < 6) begin
                op = bp_op[sent];
                a = bp_a[sent];
                b = bp_b[sent];
            end
            #1;
            if (!out_ready) begin
                hold++;
                check("bp_in_ready_hold", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (rcv < 6) check($sformatf("bp_item%0d", rcv), 32'(s), 32'(bp_exp[rcv]));
                rcv++;
            end
            fire = in_valid && in_ready;
            step();
            if (fire) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_received", 32'(rcv), 32'd6);
        check("bp_hold_cycles", 32'(hold), 32'd3);
        #1;
        if (out_valid && out_ready) rcv++;
        step();
        check("bp_no_duplicate", 32'(rcv), 32'd6);

        // Reset with two items in flight
        in_valid = 1'b1;
        op = 3'd3;
        a = 4'hA;
        b = 4'h5;
        step();
        a = 4'h3;
        step();
        in_valid = 1'b0;
        check("mid_two_in_flight", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        step();
        check("mid_no_stale", 32'(out_valid), 32'd0);

`ifdef LOGIC_UNIT_SELFTEST_EN
        // Self-test on an empty pipe: done 35 edges after the start sample
        selftest_start = 1'b1;
        step();
        selftest_start = 1'b0;
        check("st_busy", 32'(selftest_busy), 32'd1);
        done_at = 0;
        ov_seen = 1'b0;
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            step();
            if (out_valid) ov_seen = 1'b1;
            if (selftest_done) begin
                done_at = k;
                check("st_pass", 32'(selftest_pass), 32'd1);
            end
        end
        check("st_done_latency", 32'(done_at), 32'd35);
        check("st_err_count", 32'(err_count), 32'd0);
        check("st_no_out_valid", 32'(ov_seen), 32'd0);
        step();
        check("st_done_pulse", 32'(selftest_done), 32'd0);
        check("st_idle_busy", 32'(selftest_busy), 32'd0);

        // Self-test behind a stalled external item
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 3'd4;
        a = 4'hC;
        b = 4'hA;
        step();
        in_valid = 1'b0;
        step();
        check("wt_pending", 32'(out_valid), 32'd1);
        selftest_start = 1'b1;
        step();
        selftest_start = 1'b0;
        check("wt_busy", 32'(selftest_busy), 32'd1);
        check("wt_in_ready", 32'(in_ready), 32'd0);
        repeat (3) step();
        check("wt_held_valid", 32'(out_valid), 32'd1);
        check("wt_held_s", 32'(s), 32'h6);
        out_ready = 1'b1;
        #1;
        check("wt_deliver_s", 32'(s), 32'h6);
        done_at = 0;
        ov_seen = 1'b0;
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            step();
            if (out_valid) ov_seen = 1'b1;
            if (selftest_done) done_at = k;
        end
        check("wt_done_latency", 32'(done_at), 32'd36);
        check("wt_pass", 32'(selftest_pass), 32'd1);
        check("wt_no_extra_out", 32'(ov_seen), 32'd0);
        step();

        // Reset aborts a running self-test
        selftest_start = 1'b1;
        step();
        selftest_start = 1'b0;
        repeat (10) step();
        check("ab_busy", 32'(selftest_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("ab_busy_rst", 32'(selftest_busy), 32'd0);
        check("ab_pass_rst", 32'(selftest_pass), 32'd0);
        check("ab_done_rst", 32'(selftest_done), 32'd0);
        step();
        rst = 1'b0;
        #1;
`else
        // Self-test request must be inert in this build
        selftest_start = 1'b1;
        #1;
        check("off_in_ready", 32'(in_ready), 32'd1);
        repeat (3) step();
        check("off_busy", 32'(selftest_busy), 32'd0);
        check("off_done", 32'(selftest_done), 32'd0);
        check("off_pass", 32'(selftest_pass), 32'd0);
        check("off_err", 32'(err_count), 32'd0);
        run_truth_table();
        selftest_start = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
